// File: rtl/dcpu_mem_sys.sv
// Memory subsystem behind the dCPU memory port: unified RAM, TX FIFO, RX holding
// register and status register, plus a side-band preload port for RAM.
module dcpu_mem_sys #(
    parameter logic [7:0] IO_BASE  = 8'hF0,
    parameter int         TX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r_n,
    input  logic       w_n,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data_in,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       err
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);
    localparam logic [7:0] TX_ADDR = IO_BASE;
    localparam logic [7:0] ST_ADDR = IO_BASE + 8'd1;
    localparam logic [7:0] RX_ADDR = IO_BASE + 8'd2;

    logic [7:0]    r_ram [0:IO_BASE-1];
    logic [7:0]    r_fifo [0:TX_DEPTH-1];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_err;
    logic          r_rx_avail;
    logic [7:0]    r_rx_data;

    logic       w_rd, w_wr, w_conflict;
    logic       w_is_ram, w_tx_full, w_push, w_pop, w_push_ok;
    logic       w_prog_ok;
    logic [7:0] w_rdata;

    // A conflicting access is neither a read nor a write.
    assign w_conflict = !r_n && !w_n;
    assign w_rd       = !r_n && w_n;
    assign w_wr       = !w_n && r_n;
    assign w_is_ram   = (addr < IO_BASE);
    assign w_prog_ok  = prog_we && (prog_addr < IO_BASE);

    assign w_tx_full  = (r_count == FULL_CNT);
    assign tx_valid   = (r_count != '0);
    assign tx_data    = r_fifo[r_rd_ptr];
    assign w_pop      = tx_valid && tx_ready;
    assign w_push     = w_wr && (addr == TX_ADDR);
    assign w_push_ok  = w_push && (!w_tx_full || w_pop);

    assign rx_ready   = !r_rx_avail;
    assign err        = r_err;

    always_comb begin
        w_rdata = 8'h00;
        if (w_rd) begin
            if (w_is_ram)
                w_rdata = r_ram[addr];
            else if (addr == ST_ADDR)
                w_rdata = {4'b0, r_err, r_ovf, r_rx_avail, w_tx_full};
            else if (addr == RX_ADDR)
                w_rdata = r_rx_data;
        end
    end
    assign rdata = w_rdata;

    // Storage arrays carry no reset so RAM contents survive rst.
    always_ff @(posedge clk) begin
        if (w_prog_ok)
            r_ram[prog_addr] <= prog_data;
        else if (w_wr && w_is_ram && !prog_we)
            r_ram[addr] <= wdata;
        if (w_push_ok)
            r_fifo[r_wr_ptr] <= wdata;
        if (!r_rx_avail && rx_valid)
            r_rx_data <= rx_data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
            r_rx_avail <= 1'b0;
        end else begin
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_push_ok && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push_ok)
                r_count <= r_count - CW'(1);

            if (w_push && w_tx_full && !w_pop)
                r_ovf <= 1'b1;
            else if (w_wr && addr == ST_ADDR && wdata[2])
                r_ovf <= 1'b0;

            if (w_conflict)
                r_err <= 1'b1;
            else if (w_wr && addr == ST_ADDR && wdata[3])
                r_err <= 1'b0;

            if (!r_rx_avail && rx_valid)
                r_rx_avail <= 1'b1;
            else if (w_rd && addr == RX_ADDR)
                r_rx_avail <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dcpu_mem_sys.sv
// Directed self-checking bench for dcpu_mem_sys.
module tb_dcpu_mem_sys;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r_n = 1'b1, w_n = 1'b1;
    logic [7:0] addr = 8'h00, wdata = 8'h00;
    logic [7:0] rdata;
    logic       prog_we = 1'b0;
    logic [7:0] prog_addr = 8'h00, prog_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data_in = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       err;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    dcpu_mem_sys dut (
        .clk(clk), .rst(rst), .r_n(r_n), .w_n(w_n), .addr(addr), .wdata(wdata),
        .rdata(rdata), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data_in(rx_data_in), .rx_valid(rx_valid), .rx_ready(rx_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
        end else begin
            $display("ok   %s: %02h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        w_n = 1'b0; addr = a; wdata = d;
        tick();
        w_n = 1'b1;
    endtask

    task automatic cpu_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        r_n = 1'b0; addr = a;
        #1;
        check_val(tag, rdata, exp);
        tick();
        r_n = 1'b1;
    endtask

    initial begin
        #12;
        rst = 1'b0;
        tick();
        check_val("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check_val("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
        check_val("rst_err", {7'b0, err}, 8'h00);
        cpu_read("rst_status", 8'hF1, 8'h00);

        // 1. preload then read
        prog_we = 1'b1; prog_addr = 8'h07; prog_data = 8'hC1;
        tick();
        prog_we = 1'b0;
        cpu_read("preload_rd", 8'h07, 8'hC1);
        #1;
        check_val("rn_high_zero", rdata, 8'h00);

        // 2. RAM write, reserved address
        cpu_write(8'h10, 8'h2A);
        cpu_read("ram_rd_10", 8'h10, 8'h2A);
        cpu_write(8'hFE, 8'h33);
        cpu_read("reserved_rd", 8'hFE, 8'h00);

        // 3. TX overflow and drain
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) cpu_write(8'hF0, 8'h11 + 8'(i));
        cpu_read("ovf_status", 8'hF1, 8'h05);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("drain_valid%0d", i), {7'b0, tx_valid}, 8'h01);
            check_val($sformatf("drain_data%0d", i), tx_data, 8'h11 + 8'(i));
            tick();
        end
        check_val("drain_empty", {7'b0, tx_valid}, 8'h00);
        tx_ready = 1'b0;
        cpu_write(8'hF1, 8'h04);
        cpu_read("ovf_clr_status", 8'hF1, 8'h00);

        // 4. full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) cpu_write(8'hF0, 8'hA1 + 8'(i));
        cpu_read("full_status", 8'hF1, 8'h01);
        tx_ready = 1'b1;
        cpu_write(8'hF0, 8'h99);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("pp_data%0d", i), tx_data, (i == 3) ? 8'h99 : 8'hA2 + 8'(i));
            tick();
        end
        check_val("pp_empty", {7'b0, tx_valid}, 8'h00);
        tx_ready = 1'b0;
        cpu_read("pp_status", 8'hF1, 8'h00);

        // 5. RX path
        rx_valid = 1'b1; rx_data_in = 8'h5A;
        tick();
        rx_valid = 1'b0;
        check_val("rx_ready_busy", {7'b0, rx_ready}, 8'h00);
        cpu_read("rx_status", 8'hF1, 8'h02);
        rx_valid = 1'b1; rx_data_in = 8'h77;
        tick();
        rx_valid = 1'b0;
        cpu_read("rx_data", 8'hF2, 8'h5A);
        check_val("rx_ready_free", {7'b0, rx_ready}, 8'h01);
        cpu_read("rx_status_clr", 8'hF1, 8'h00);

        // 6. conflict then asynchronous reset
        r_n = 1'b0; w_n = 1'b0; addr = 8'h10; wdata = 8'hFF;
        #1;
        check_val("conflict_rdata", rdata, 8'h00);
        tick();
        r_n = 1'b1; w_n = 1'b1;
        check_val("conflict_err", {7'b0, err}, 8'h01);
        cpu_read("conflict_status", 8'hF1, 8'h08);
        cpu_read("conflict_ram", 8'h10, 8'h2A);
        cpu_write(8'hF0, 8'h01);
        cpu_write(8'hF0, 8'h02);
        check_val("pre_rst_valid", {7'b0, tx_valid}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_valid", {7'b0, tx_valid}, 8'h00);
        check_val("async_rst_err", {7'b0, err}, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        cpu_read("ram_retained", 8'h10, 8'h2A);
        cpu_read("post_rst_status", 8'hF1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/dcpu_mem_sys.md
Name: dcpu_mem_sys

Overview:
Memory subsystem that sits directly downstream of the dCPU core's memory port. It consumes the CPU's active-low R/W strobes, address and write data, and returns read data. It provides a unified RAM plus a small memory-mapped I/O window: a buffered TX byte port, a single-entry RX byte port, and a status register. A side-band program-load port lets the bench preload RAM while the CPU is held in reset.

Parameters:
IO_BASE, 8'hF0, first I/O address; addresses 0x00..IO_BASE-1 are RAM.
TX_DEPTH, 4, TX FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
r_n  input  1  CPU read strobe, active low
w_n  input  1  CPU write strobe, active low
addr  input  8  CPU address
wdata  input  8  CPU write data (CPU data_out)
rdata  output  8  read data to CPU mem_in; combinational
prog_we  input  1  preload write enable
prog_addr  input  8  preload address
prog_data  input  8  preload data
tx_data  output  8  TX FIFO head byte
tx_valid  output  1  TX FIFO non-empty
tx_ready  input  1  consumer accepts tx_data this cycle
rx_data_in  input  8  incoming RX byte
rx_valid  input  1  RX byte offered
rx_ready  output  1  RX holding register empty
err  output  1  sticky: simultaneous read and write seen

Behaviour:
- Reset clears control state only:
  - TX pointers and count = 0, so tx_valid=0.
  - rx_avail=0, so rx_ready=1.
  - ovf=0, err=0.
  - RAM contents are not reset and are retained across rst.
  - Effect is immediate (asynchronous).
- Address decode:
  - RAM: addr < IO_BASE.
  - TXDATA: IO_BASE+0.
  - STATUS: IO_BASE+1.
  - RXDATA: IO_BASE+2.
  - Reserved: IO_BASE+3..0xFF. Reads return 0x00; writes are ignored.
- Read path, combinational, zero latency:
  - rdata is valid in the same cycle r_n is low.
  - r_n high gives rdata=0x00.
  - RAM read is asynchronous: RAM[addr].
  - TXDATA read returns 0x00.
  - STATUS read returns {4'b0, err, ovf, rx_avail, tx_full}.
  - RXDATA read returns the RX holding register.
- Write path:
  - At posedge with w_n low, the access commits.
  - RAM addresses: RAM[addr] <= wdata.
  - TXDATA: push.
  - STATUS: write-1-to-clear; wdata[2] clears ovf, wdata[3] clears err; other bits are ignored.
- Conflict (r_n=0 and w_n=0 in the same cycle):
  - The write is suppressed and rdata is forced to 0x00.
  - err is set at posedge.
  - No read side effects occur.
- Preload:
  - prog_we at posedge writes RAM[prog_addr] when prog_addr < IO_BASE; otherwise it is ignored.
  - If prog_we and a CPU RAM write occur in the same cycle, prog wins and the CPU write is dropped.
- TX FIFO:
  - Circular buffer of TX_DEPTH entries; tx_data = head.
  - Pop when tx_valid && tx_ready at posedge.
  - Push is accepted when not full, or when full and a pop occurs in the same cycle (count unchanged).
  - Push when full with no pop: byte is dropped, ovf is set, FIFO is unchanged.
  - Simultaneous push and pop when empty: push only (tx_valid was 0).
  - Pointers wrap modulo TX_DEPTH.
  - tx_full = (count == TX_DEPTH).
- RX port:
  - rx_ready = !rx_avail.
  - At posedge with rx_valid && rx_ready: capture rx_data_in and set rx_avail.
  - A CPU read of RXDATA (r_n=0, w_n=1) at posedge clears rx_avail.
  - Capture and clear cannot coincide, because capture requires rx_avail=0.
  - Reading RXDATA when rx_avail=0 returns the stale byte and has no effect.
- Strobes are level-sampled once per posedge. The CPU holds r_n/w_n for exactly one clock period, so each access commits exactly once.

Test Plan:
1. Preload read: prog write RAM[0x07]=0xC1, then r_n=0, addr=0x07 -> rdata=0xC1 in the same cycle; raise r_n -> rdata=0x00.
2. RAM write: w_n=0, addr=0x10, wdata=0x2A for one cycle, then read 0x10 -> 0x2A. A write to 0xFE is ignored, and a read of 0xFE returns 0x00.
3. TX overflow and drain, with tx_ready=0:
   - Write 0x11..0x15 to 0xF0; STATUS reads 0x05.
   - Set tx_ready=1 -> tx_data sequence 0x11, 0x12, 0x13, 0x14, one byte per cycle; tx_valid=0 after the 4th.
   - Write 0x04 to 0xF1 -> STATUS reads 0x00.
4. TX full with simultaneous push and pop: fill 4 entries, tx_ready=1, push 0x99 in the same cycle -> ovf stays 0, 0x99 emerges 4th after that cycle.
5. RX:
   - rx_valid=1 with 0x5A for one cycle -> rx_ready=0 and STATUS=0x02.
   - A second rx_valid with 0x77 is not captured.
   - Read 0xF2 -> rdata=0x5A; after that posedge, rx_ready=1 and STATUS=0x00.
6. Conflict and reset:
   - r_n=0, w_n=0, addr=0x10, wdata=0xFF -> RAM[0x10] stays 0x2A, rdata=0x00, err=1, STATUS=0x08.
   - Load 2 TX bytes, then assert rst mid-cycle -> tx_valid=0 and err=0 immediately; RAM[0x10] still reads 0x2A.
